// File: rtl/vx_gpr_operand_fetch_pkg.sv
// Shared types for the GPR operand-fetch stage: widths, the fetch state
// enum, and the scoreboard/operand payload structs.
package vx_gpr_operand_fetch_pkg;

  localparam int NUM_THREADS  = 4;
  localparam int XLEN         = 32;
  localparam int NR_BITS      = 5;
  localparam int ISSUE_WIS_W  = 2;
  localparam int UUID_W       = 16;
  localparam int PC_W         = 32;
  localparam int EX_TYPE_W    = 2;
  localparam int OP_TYPE_W    = 4;
  localparam int OP_ARGS_W    = 8;
  localparam int INFL_ID_W    = 4;
  localparam int NUM_SRC_OPDS = 3;
  localparam int DATA_W       = NUM_THREADS * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [ISSUE_WIS_W-1:0] wis;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic [EX_TYPE_W-1:0]   ex_type;
    logic [OP_TYPE_W-1:0]   op_type;
    logic [OP_ARGS_W-1:0]   op_args;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
    logic [INFL_ID_W-1:0]   infl_id;
  } sb_data_t;

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [ISSUE_WIS_W-1:0] wis;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic [EX_TYPE_W-1:0]   ex_type;
    logic [OP_TYPE_W-1:0]   op_type;
    logic [OP_ARGS_W-1:0]   op_args;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [INFL_ID_W-1:0]   infl_id;
    logic [DATA_W-1:0]      rs1_data;
    logic [DATA_W-1:0]      rs2_data;
    logic [DATA_W-1:0]      rs3_data;
  } op_data_t;

  function automatic logic [NR_BITS-1:0] src_reg(input sb_data_t d, input logic [1:0] idx);
    case (idx)
      2'd0:    src_reg = d.rs1;
      2'd1:    src_reg = d.rs2;
      default: src_reg = d.rs3;
    endcase
  endfunction

endpackage

// File: rtl/vx_gpr_operand_fetch_if.sv
// Valid/ready handshake interfaces between scoreboard, operand fetch and dispatch.
interface VX_scoreboard_if;
  import vx_gpr_operand_fetch_pkg::*;
  logic     valid;
  sb_data_t data;
  logic     ready;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface VX_operands_if;
  import vx_gpr_operand_fetch_pkg::*;
  logic     valid;
  op_data_t data;
  logic     ready;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vx_gpr_operand_fetch.sv
// Fetches rs1/rs2/rs3 one per cycle through a single-port, 1-cycle-latency
// GPR bank and holds the assembled instruction until dispatch accepts it.
module vx_gpr_operand_fetch
  import vx_gpr_operand_fetch_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter bit    SKIP_X0     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  VX_scoreboard_if.slave         scoreboard_if,
  output logic                   gpr_rd_en,
  output logic [ISSUE_WIS_W-1:0] gpr_rd_wis,
  output logic [NR_BITS-1:0]     gpr_rd_addr,
  input  logic [DATA_W-1:0]      gpr_rd_data,
  VX_operands_if.master          operands_if
);

  fetch_state_e state_reg, state_next;
  logic [1:0]   src_idx_reg, src_idx_next;
  sb_data_t     instr_reg;
  logic         tag_en_reg;
  logic [1:0]   tag_slot_reg;

  logic                               sb_ready;
  logic                               accept;
  logic                               rd_req;
  logic [NR_BITS-1:0]                 rd_sel;
  logic [NUM_SRC_OPDS-1:0][DATA_W-1:0] slot_data;
  op_data_t                           out_data;

  always_comb begin
    state_next   = state_reg;
    src_idx_next = src_idx_reg;
    sb_ready     = 1'b0;
    rd_req       = 1'b0;
    rd_sel       = src_reg(instr_reg, src_idx_reg);
    case (state_reg)
      IDLE: sb_ready = 1'b1;
      READ: begin
        rd_req = !(SKIP_X0 && (rd_sel == '0));
        if (src_idx_reg == 2'd2) begin
          state_next   = WAIT;
          src_idx_next = 2'd0;
        end else begin
          src_idx_next = src_idx_reg + 2'd1;
        end
      end
      WAIT: state_next = OUT;
      OUT: begin
        sb_ready = operands_if.ready;
        if (operands_if.ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    sb_ready = sb_ready & ~reset;
    // A new accept overrides OUT->IDLE so the next fetch starts back-to-back.
    if (sb_ready && scoreboard_if.valid) begin
      state_next   = READ;
      src_idx_next = 2'd0;
    end
  end

  assign accept = sb_ready & scoreboard_if.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      src_idx_reg  <= 2'd0;
      instr_reg    <= '0;
      tag_en_reg   <= 1'b0;
      tag_slot_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      src_idx_reg  <= src_idx_next;
      tag_en_reg   <= rd_req;
      tag_slot_reg <= src_idx_reg;
      if (accept) instr_reg <= scoreboard_if.data;
    end
  end

  // Slots are cleared on accept so skipped x0 sources read back as zero.
  for (genvar gi = 0; gi < NUM_SRC_OPDS; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_reg;
    always_ff @(posedge clk) begin
      if (reset || accept) begin
        slot_reg <= '0;
      end else if (tag_en_reg && (tag_slot_reg == 2'(gi))) begin
        slot_reg <= gpr_rd_data;
      end
    end
    assign slot_data[gi] = slot_reg;
  end

  always_comb begin
    out_data          = '0;
    out_data.uuid     = instr_reg.uuid;
    out_data.wis      = instr_reg.wis;
    out_data.tmask    = instr_reg.tmask;
    out_data.PC       = instr_reg.PC;
    out_data.ex_type  = instr_reg.ex_type;
    out_data.op_type  = instr_reg.op_type;
    out_data.op_args  = instr_reg.op_args;
    out_data.wb       = instr_reg.wb;
    out_data.rd       = instr_reg.rd;
    out_data.infl_id  = instr_reg.infl_id;
    out_data.rs1_data = slot_data[0];
    out_data.rs2_data = slot_data[1];
    out_data.rs3_data = slot_data[2];
  end

  assign gpr_rd_en           = rd_req & ~reset;
  assign gpr_rd_addr         = rd_sel;
  assign gpr_rd_wis          = instr_reg.wis;
  assign scoreboard_if.ready = sb_ready;
  assign operands_if.valid   = (state_reg == OUT) & ~reset;
  assign operands_if.data    = out_data;

endmodule
